// File: rtl/fir_pkg.sv
// Shared types and helpers for the serial-MAC FIR: FSM states, default lowpass taps,
// a constant clog2 and the shift-then-saturate used on the accumulator output.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam int DEF_NTAPS = 19;
  localparam int SAT_W     = 128;

  // Symmetric 19-tap lowpass, centre tap 19660.
  localparam logic signed [15:0] DEFAULT_COEF [DEF_NTAPS] = '{
    16'sd26,    16'sd270,   16'sd963,   16'sd2424,  16'sd4869,
    16'sd8259,  16'sd12194, 16'sd15948, 16'sd18666, 16'sd19660,
    16'sd18666, 16'sd15948, 16'sd12194, 16'sd8259,  16'sd4869,
    16'sd2424,  16'sd963,   16'sd270,   16'sd26
  };

  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((32'd1 << i) < n) w = i + 1;
    return w;
  endfunction

  function automatic logic signed [31:0] default_coef(input int i);
    return (i < DEF_NTAPS) ? 32'(DEFAULT_COEF[i[4:0]]) : 32'sd0;
  endfunction

  // Arithmetic (floor) shift, then clamp to the signed range of dw bits.
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] a,
                                                         input int sh, input int dw);
    logic signed [SAT_W-1:0] s, hi, lo;
    s  = a >>> sh;
    hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Single shared multiply-accumulate: acc <= 0 on clear, acc += sample*coef on enable.
// One-cycle registered result; no handshake, the caller sequences clear/enable.
module fir_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;

  assign prod = sample * coef;

  always_ff @(posedge clk) begin
    if (rst || clear) acc <= '0;
    else if (enable)  acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/serial_mac_fir.sv
// Time-multiplexed FIR: one tap per clock, result valid NTAPS+1 cycles after the input handshake.
// Holds the result in OUT until m_axis_data_tready; s_axis_data_tready is low while busy.
module serial_mac_fir
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NTAPS     = 19,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_data_tvalid,
  output logic                      s_axis_data_tready,
  input  logic signed [DATA_W-1:0]  s_axis_data_tdata,
  output logic                      m_axis_data_tvalid,
  input  logic                      m_axis_data_tready,
  output logic signed [DATA_W-1:0]  m_axis_data_tdata,
  input  logic                      cfg_we,
  input  logic [clog2(NTAPS)-1:0]   cfg_addr,
  input  logic signed [COEF_W-1:0]  cfg_data,
  output logic                      cfg_ready,
  output logic                      busy
);

  localparam int          AW   = clog2(NTAPS);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  state_t state_q, state_d;
  logic [AW-1:0] wptr_q, rptr_q, k_q;
  logic signed [DATA_W-1:0] dline [NTAPS];
  logic signed [COEF_W-1:0] coef  [NTAPS];
  logic signed [ACC_W-1:0]  acc;
  logic accept, cfg_wr, mac_clear, mac_en;

  assign accept    = s_axis_data_tvalid & s_axis_data_tready;
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign cfg_wr    = cfg_we & cfg_ready & (int'(cfg_addr) < NTAPS);

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    s_axis_data_tready = 1'b0;
    m_axis_data_tvalid = 1'b0;
    mac_clear          = 1'b0;
    mac_en             = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_axis_data_tready = 1'b1;
        if (s_axis_data_tvalid) begin
          mac_clear = 1'b1;
          state_d   = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == LAST) state_d = OUT;
      end
      OUT: begin
        m_axis_data_tvalid = 1'b1;
        if (m_axis_data_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rptr walks backwards from the newest sample so tap k sees sample n-k.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      k_q    <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        dline[AW'(i)] <= '0;
        coef[AW'(i)]  <= (NTAPS == DEF_NTAPS) ? COEF_W'(default_coef(i)) : '0;
      end
    end else begin
      if (cfg_wr) coef[cfg_addr] <= cfg_data;
      if (accept) begin
        dline[wptr_q] <= s_axis_data_tdata;
        rptr_q        <= wptr_q;
        k_q           <= '0;
      end
      if (mac_en) begin
        k_q    <= k_q + 1'b1;
        rptr_q <= (rptr_q == '0) ? LAST : rptr_q - 1'b1;
        if (k_q == LAST) wptr_q <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      end
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (aclk),
    .rst    (areset),
    .clear  (mac_clear),
    .enable (mac_en),
    .sample (dline[rptr_q]),
    .coef   (coef[k_q]),
    .acc    (acc)
  );

  // acc is frozen outside MAC, so the OUT value stays stable under back-pressure.
  assign m_axis_data_tdata = (state_q == OUT)
                           ? DATA_W'(sat_shift(SAT_W'(acc), OUT_SHIFT, DATA_W)) : '0;

endmodule

// File: tb/tb_serial_mac_fir.sv
// Bench for serial_mac_fir: two instances (OUT_SHIFT 0 and 15) driven in lockstep,
// table vectors plus hand sequences, checked through an expected-value queue.
module tb_serial_mac_fir;

  localparam int N = 19;
  localparam int IMP [N] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660,
                             18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               areset = 1'b1;
  logic               s_tvalid = 1'b0;
  logic signed [15:0] s_tdata = '0;
  logic               m_tready = 1'b1;
  logic               cfg_we = 1'b0;
  logic [4:0]         cfg_addr = '0;
  logic signed [15:0] cfg_data = '0;

  logic s_tready0, m_tvalid0, cfg_ready0, busy0;
  logic s_tready15, m_tvalid15, cfg_ready15, busy15;
  logic signed [15:0] m_tdata0, m_tdata15;

  serial_mac_fir #(.OUT_SHIFT(0)) u0 (
    .aclk(clk), .areset(areset),
    .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready0), .s_axis_data_tdata(s_tdata),
    .m_axis_data_tvalid(m_tvalid0), .m_axis_data_tready(m_tready), .m_axis_data_tdata(m_tdata0),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready0), .busy(busy0)
  );

  serial_mac_fir #(.OUT_SHIFT(15)) u15 (
    .aclk(clk), .areset(areset),
    .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready15), .s_axis_data_tdata(s_tdata),
    .m_axis_data_tvalid(m_tvalid15), .m_axis_data_tready(m_tready), .m_axis_data_tdata(m_tdata15),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready15), .busy(busy15)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // ---------------- reference model + scoreboard (monitor owns all of it) ----------------
  typedef struct {int e0; int e15;} exp_t;
  exp_t sb[$];
  int   hist [N];
  int   mc   [N];
  int   cyc = 0;
  int   last_acc = 0, last_out = 0;
  logic have_prev = 1'b0, prev_vld = 1'b0;
  exp_t mon_e;
  longint mon_sum;

  // written only by the stimulus process
  logic spacing_on = 1'b0;
  logic nxt_has0 = 1'b0, nxt_has15 = 1'b0;
  int   nxt_e0 = 0, nxt_e15 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (areset) begin
      for (int j = 0; j < N; j++) begin
        hist[j] = 0;
        mc[j]   = IMP[j];
      end
      sb.delete();
      have_prev = 1'b0;
      prev_vld  = 1'b0;
    end else begin
      if (cfg_we && cfg_ready0 && cfg_addr < N) mc[cfg_addr] = int'(cfg_data);
      if (s_tvalid && s_tready0) begin
        if (spacing_on && have_prev) check("handshake_spacing", cyc - last_acc, N + 2);
        have_prev = 1'b1;
        last_acc  = cyc;
        for (int j = N - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = int'(s_tdata);
        mon_sum = 0;
        for (int j = 0; j < N; j++) mon_sum += longint'(hist[j]) * longint'(mc[j]);
        mon_e.e0  = nxt_has0  ? nxt_e0  : sat16(mon_sum);
        mon_e.e15 = nxt_has15 ? nxt_e15 : sat16(mon_sum >>> 15);
        sb.push_back(mon_e);
      end
      if (m_tvalid0 && !prev_vld) check("latency", cyc - last_acc, N + 1);
      prev_vld = m_tvalid0;
      if (m_tvalid0 && m_tready) begin
        last_out = cyc;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0d, expected no output", m_tdata0);
        end else begin
          mon_e = sb.pop_front();
          check("out_shift0", m_tdata0, mon_e.e0);
          check("out_shift15", m_tdata15, mon_e.e15);
          check("valid_shift15", m_tvalid15, 1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_dut();
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
  endtask

  task automatic send(input int x, input logic h0, input int e0, input logic h15, input int e15);
    int t = 0;
    while (!s_tready0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_tready0) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: s_tready=%0d, expected 1", s_tready0);
    end
    nxt_has0 = h0;  nxt_e0 = e0;
    nxt_has15 = h15; nxt_e15 = e15;
    s_tvalid = 1'b1;
    s_tdata  = 16'(x);
    @(posedge clk); #1;
    s_tvalid  = 1'b0;
    nxt_has0  = 1'b0;
    nxt_has15 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs pending, expected 0", sb.size());
    end
  endtask

  typedef struct {logic rst; int x; logic h0; int e0; logic h15; int e15;} vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input int x, input logic h0, input int e0,
                     input logic h15, input int e15);
    vec_t v;
    v = '{rst, x, h0, e0, h15, e15};
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t, bad_d, bad_v, bad_r;
    int dc_x [4]   = '{100, -100, 16384, -16384};
    int dc_e0 [4]  = '{32767, -32768, 32767, -32768};
    int dc_e15 [4] = '{448, -449, 32767, -32768};

    // impulse (no reset: follows the mid-MAC reset sequence), then DC / saturation groups
    for (int j = 0; j < N + 2; j++) add(1'b0, (j == 0) ? 1 : 0, 1'b1, (j < N) ? IMP[j] : 0, 1'b1, 0);
    for (int g = 0; g < 4; g++)
      for (int j = 0; j < N + 1; j++)
        add(j == 0, dc_x[g], j >= N - 1, dc_e0[g], j >= N - 1, dc_e15[g]);

    // reset values
    reset_dut();
    check("rst_s_tready", s_tready0, 1);
    check("rst_m_tvalid", m_tvalid0, 0);
    check("rst_m_tdata", m_tdata0, 0);
    check("rst_m_tdata15", m_tdata15, 0);
    check("rst_busy", busy0, 0);
    check("rst_cfg_ready", cfg_ready0, 1);

    // coefficient writes: IDLE write, ignored MAC write, write coincident with accept
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'sd1000;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    send(1, 1'b1, 1000, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1;
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = 16'sd5555;
    check("cfg_ready_in_mac", cfg_ready0, 0);
    check("busy_in_mac", busy0, 1);
    check("s_tready_in_mac", s_tready0, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    drain();
    send(0, 1'b1, 270, 1'b1, 0);
    drain();
    cfg_we = 1'b1; cfg_addr = 5'd2; cfg_data = -16'sd7;
    send(0, 1'b1, -7, 1'b1, -1);
    cfg_we = 1'b0;
    drain();

    // back-pressure: 50 stalled cycles with an input offered throughout
    reset_dut();
    m_tready = 1'b0;
    send(1, 1'b1, 26, 1'b1, 0);
    t = 0;
    while (!m_tvalid0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_valid_seen", m_tvalid0, 1);
    s_tvalid = 1'b1; s_tdata = 16'sd0;
    bad_d = 0; bad_v = 0; bad_r = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (m_tdata0 !== 16'sd26) bad_d++;
      if (m_tvalid0 !== 1'b1)   bad_v++;
      if (s_tready0 !== 1'b0)   bad_r++;
    end
    check("bp_data_unstable_cycles", bad_d, 0);
    check("bp_valid_dropped_cycles", bad_v, 0);
    check("bp_tready_high_cycles", bad_r, 0);
    m_tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    check("bp_accept_gap", last_acc - last_out, 1);
    drain();

    // reset in the middle of a MAC sequence, with history already in the delay line
    reset_dut();
    send(1, 1'b0, 0, 1'b0, 0);
    drain();
    send(5, 1'b0, 0, 1'b0, 0);
    drain();
    send(3, 1'b0, 0, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("midmac_busy_before", busy0, 1);
    areset = 1'b1;
    @(posedge clk); #1;
    check("midmac_m_tvalid", m_tvalid0, 0);
    check("midmac_s_tready", s_tready0, 1);
    check("midmac_busy", busy0, 0);
    check("midmac_cfg_ready", cfg_ready0, 1);
    areset = 1'b0;

    // table-driven vectors with back-to-back handshakes
    spacing_on = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) reset_dut();
      send(tbl[i].x, tbl[i].h0, tbl[i].e0, tbl[i].h15, tbl[i].e15);
      drain();
    end
    spacing_on = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_mac_fir.md
Name: serial_mac_fir

Overview:
- Parametrised, resource-optimised FIR filter for AXI-Stream sample paths.
- One shared multiply-accumulate (MAC) unit is time-multiplexed over all taps: one tap per clock.
- Circular-buffer delay line; coefficients are run-time loadable.
- Output is rounded-by-truncation, shifted and saturated.
- Successor to the fixed 19-tap filter. Adds proper AXI back-pressure, a reset, a configurable tap count and widths, and a coefficient write port.

Parameters:
- DATA_W, 16, input/output sample width (signed two's complement)
- COEF_W, 16, coefficient width (signed)
- NTAPS, 19, number of taps (2..256)
- ACC_W, 40, accumulator width (must be ≥ DATA_W+COEF_W+clog2(NTAPS))
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation

Ports:
- aclk, in, 1, clock
- areset, in, 1, synchronous active-high reset
- s_axis_data_tvalid, in, 1, input sample valid
- s_axis_data_tready, out, 1, block accepts a sample
- s_axis_data_tdata, in, DATA_W, input sample (signed)
- m_axis_data_tvalid, out, 1, output sample valid
- m_axis_data_tready, in, 1, downstream accepts
- m_axis_data_tdata, out, DATA_W, filtered sample (signed)
- cfg_we, in, 1, coefficient write strobe
- cfg_addr, in, clog2(NTAPS), coefficient index
- cfg_data, in, COEF_W, coefficient value (signed)
- cfg_ready, out, 1, high when a coefficient write is accepted
- busy, out, 1, MAC sequence in progress

Behaviour:
- One clock (aclk). Reset is synchronous and active-high (areset); all state updates on the rising edge of aclk.
- Reset values:
  - State = IDLE.
  - s_axis_data_tready = 1.
  - m_axis_data_tvalid = 0, m_axis_data_tdata = 0.
  - busy = 0, cfg_ready = 1.
  - Delay line cleared to 0; write pointer = 0.
  - Coefficients loaded from the package default table (symmetric 19-tap lowpass: 26,270,963,2424,4869,8259,12194,15948,18666,19660, mirrored). If NTAPS≠19, coefficients are cleared to 0.
- State machine:
  - IDLE: s_tready=1. On s_tvalid & s_tready:
    - write the sample at wptr;
    - clear the accumulator;
    - tap index k=0, read pointer rptr=wptr;
    - go to MAC.
  - MAC: each cycle, acc += x[rptr]*c[k].
    - rptr decrements, wrapping from 0 to NTAPS-1; k increments.
    - After the cycle with k=NTAPS-1: go to OUT; wptr advances, wrapping at NTAPS-1 → 0.
  - OUT: m_tdata = sat(acc >>> OUT_SHIFT) to the DATA_W signed range; m_tvalid=1.
    - Hold data and valid stable until m_tready.
    - On m_tvalid & m_tready → IDLE. The next sample may be accepted in the following cycle.
- Timing:
  - Latency from input handshake to m_tvalid: NTAPS+1 cycles.
  - Minimum sample interval: NTAPS+2 cycles.
  - s_tready=0 in MAC and OUT.
- Delay-line indexing: x[wptr] is the newest sample, x[wptr-j mod NTAPS] is sample n-j. Tap 0 multiplies the newest sample.
- Arithmetic:
  - Products are full width, DATA_W+COEF_W, signed.
  - The accumulator is ACC_W signed with no intermediate overflow check.
  - The shift is arithmetic (floor).
  - Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Coefficient port:
  - cfg_ready = (state==IDLE).
  - A write occurs only when cfg_we & cfg_ready; cfg_we while not ready is ignored, with no queuing.
  - cfg_addr ≥ NTAPS is ignored.
  - A write and a sample accept in the same IDLE cycle: the new coefficient is used for that sample.
- busy = (state!=IDLE).
- Reset in any state aborts the computation, discards any pending output and drops m_tvalid in the next cycle. Coefficients return to the defaults.
- Back-pressure: an indefinite m_tready=0 stalls the block in OUT; no input is accepted and no data is lost.

Decomposition:
- Package fir_pkg contains:
  - state enum {IDLE, MAC, OUT};
  - default 19-entry coefficient table;
  - clog2 function;
  - saturating-shift function.
- One sub-module, fir_mac. Inputs: clear, enable, sample, coefficient. Output: registered ACC_W accumulator. It contains the only multiplier in the block.

Test Plan:
- Impulse test, OUT_SHIFT=0, default coefficients. Input 1 followed by 0s → outputs 26,270,963,2424,4869,8259,12194,15948,18666,19660,18666,…,26, then 0.
- DC test, OUT_SHIFT=15. Constant input 100 → output settles at 448 after 19 samples. Constant −100 → output settles at −449 (floor behaviour).
- Saturation test. Constant 16384 → output settles at 32767. Constant −16384 → output settles at −32768.
- Back-pressure test. Hold m_tready=0 for 50 cycles:
  - m_tdata and m_tvalid stay stable and s_tready stays 0;
  - after m_tready=1, the next sample is accepted one cycle later;
  - spacing between handshakes with m_tready=1 is exactly NTAPS+2 = 21 cycles.
- Coefficient write test:
  - Write c[0]=1000 in IDLE, then send an impulse of 1 with OUT_SHIFT=0 → first output is 1000.
  - cfg_we asserted during MAC is ignored; cfg_ready is 0 at that time.
- Mid-MAC reset test. Assert areset during MAC:
  - next cycle m_tvalid=0, s_tready=1, busy=0;
  - a subsequent impulse reproduces the default impulse response, confirming the delay line was cleared.
